// File: rtl/song_sequencer.sv
// -----------------------------------------------------------------------------
// song_sequencer
//
// Transport controller for the song record/playback address path. Turns
// debounced single-cycle user commands plus a song-slot selection into the
// start/pause/record controls for the address calculator. It also tracks
// song_done to end or loop a take, and gates the memory write strobe.
//
// Optional build macro: LOOP_PLAYBACK_EN
//   defined   : a finished playback take restarts from ARM with the same slot
//               until stop_cmd_i is seen (stop in the DONE cycle wins).
//   undefined : DONE always returns to IDLE.
//
// Parameters
//   VALID_MASK    : bit i set means song_sel_i == i is a legal slot.
//   SETTLE_CYCLES : cycles (1..3) after the start pulse with song_done ignored.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   rec_cmd_i       : single-cycle record request
//   play_cmd_i      : single-cycle play request
//   pause_cmd_i     : single-cycle pause/resume toggle
//   stop_cmd_i      : single-cycle stop
//   song_sel_i      : requested song slot (sampled only in IDLE)
//   ready_i         : audio sample strobe
//   song_done_i     : end-of-song flag from the address calculator
//   start_song_o    : one-cycle start pulse (registered)
//   pause_song_o    : hold the address calculator (registered)
//   record_mode_o   : 1 = record, 0 = playback, latched per take (registered)
//   song_choice_o   : slot latched for the current take (registered)
//   mem_we_o        : memory write enable (combinational)
//   done_pulse_o    : one-cycle end-of-take pulse (registered)
//   bad_cmd_o       : one-cycle pulse when a command is rejected (registered)
//   recorded_o      : per-slot "has content" flags (registered)
//   state_out_o     : current state encoding for debug LEDs (registered)
//
// Command handshake: commands are one-cycle strobes with no ready/ack. The
// cycle a strobe is high is the cycle it is consumed; when several are high
// together only the highest priority one (stop > rec > play > pause) acts.
// -----------------------------------------------------------------------------
module song_sequencer #(
    parameter logic [15:0] VALID_MASK    = 16'h3F3F,
    parameter int          SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rec_cmd_i,
    input  logic        play_cmd_i,
    input  logic        pause_cmd_i,
    input  logic        stop_cmd_i,
    input  logic [3:0]  song_sel_i,
    input  logic        ready_i,
    input  logic        song_done_i,
    output logic        start_song_o,
    output logic        pause_song_o,
    output logic        record_mode_o,
    output logic [3:0]  song_choice_o,
    output logic        mem_we_o,
    output logic        done_pulse_o,
    output logic        bad_cmd_o,
    output logic [15:0] recorded_o,
    output logic [2:0]  state_out_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_SETTLE = 3'd2,
        S_RECORD = 3'd3,
        S_PLAY   = 3'd4,
        S_PAUSED = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  settle_q, settle_d;
    logic        record_mode_q, record_mode_d;
    logic [3:0]  song_choice_q, song_choice_d;
    logic [15:0] recorded_q, recorded_d;
    logic        bad_d;
    logic        start_song_q, pause_song_q, done_pulse_q, bad_cmd_q;

    // Priority-resolved command winners; at most one is high.
    logic win_stop, win_rec, win_play, win_pause;
    assign win_stop  = stop_cmd_i;
    assign win_rec   = rec_cmd_i & ~stop_cmd_i;
    assign win_play  = play_cmd_i & ~stop_cmd_i & ~rec_cmd_i;
    assign win_pause = pause_cmd_i & ~stop_cmd_i & ~rec_cmd_i & ~play_cmd_i;

    always_comb begin
        state_d       = state_q;
        settle_d      = settle_q;
        record_mode_d = record_mode_q;
        song_choice_d = song_choice_q;
        recorded_d    = recorded_q;
        bad_d         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (win_rec) begin
                    if (VALID_MASK[song_sel_i]) begin
                        song_choice_d = song_sel_i;
                        record_mode_d = 1'b1;
                        state_d       = S_ARM;
                    end else begin
                        bad_d = 1'b1;
                    end
                end else if (win_play) begin
                    if (VALID_MASK[song_sel_i] && recorded_q[song_sel_i]) begin
                        song_choice_d = song_sel_i;
                        record_mode_d = 1'b0;
                        state_d       = S_ARM;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            S_ARM: begin
                settle_d = 2'd0;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                // song_done may still reflect the previous take here.
                if (settle_q == SETTLE_LAST) begin
                    state_d = record_mode_q ? S_RECORD : S_PLAY;
                end else begin
                    settle_d = settle_q + 2'd1;
                end
            end
            S_RECORD, S_PLAY: begin
                if (win_stop) begin
                    state_d = S_IDLE;
                end else if (song_done_i) begin
                    state_d = S_DONE;
                end else if (win_rec || win_play) begin
                    bad_d = 1'b1;
                end else if (win_pause) begin
                    state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (win_stop) begin
                    state_d = S_IDLE;
                end else if (win_rec) begin
                    bad_d = 1'b1;
                end else if (win_play || win_pause) begin
                    // Resume the same take; song_sel_i is not re-sampled.
                    state_d = record_mode_q ? S_RECORD : S_PLAY;
                end
            end
            S_DONE: begin
`ifdef LOOP_PLAYBACK_EN
                if (stop_cmd_i || record_mode_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ARM;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_RECORD) begin
            recorded_d[song_choice_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            settle_q      <= 2'd0;
            record_mode_q <= 1'b0;
            song_choice_q <= 4'd0;
            recorded_q    <= 16'd0;
            start_song_q  <= 1'b0;
            pause_song_q  <= 1'b1;
            done_pulse_q  <= 1'b0;
            bad_cmd_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_q      <= settle_d;
            record_mode_q <= record_mode_d;
            song_choice_q <= song_choice_d;
            recorded_q    <= recorded_d;
            // Output flags are decoded from the next state so they line up
            // with the registered state they describe.
            start_song_q  <= (state_d == S_ARM);
            pause_song_q  <= (state_d == S_IDLE) || (state_d == S_PAUSED) ||
                             (state_d == S_DONE);
            done_pulse_q  <= (state_d == S_DONE);
            bad_cmd_q     <= bad_d;
        end
    end

    assign start_song_o  = start_song_q;
    assign pause_song_o  = pause_song_q;
    assign record_mode_o = record_mode_q;
    assign song_choice_o = song_choice_q;
    assign done_pulse_o  = done_pulse_q;
    assign bad_cmd_o     = bad_cmd_q;
    assign recorded_o    = recorded_q;
    assign state_out_o   = state_q;
    assign mem_we_o      = (state_q == S_RECORD) & ready_i & ~song_done_i;

endmodule

// File: tb/tb_song_sequencer.sv
// -----------------------------------------------------------------------------
// tb_song_sequencer
//
// Directed bench for song_sequencer. Each applied vector pushes the expected
// packed output word onto exp_q; after the clock edge the observed word is
// popped against it. Packed word layout (29 bits):
//   {state[2:0], start, pause, record_mode, choice[3:0], done, bad, mem_we,
//    recorded[15:0]}
// -----------------------------------------------------------------------------
module tb_song_sequencer;

    localparam int W = 29;

    localparam logic [3:0] C_NONE  = 4'b0000;
    localparam logic [3:0] C_PAUSE = 4'b0001;
    localparam logic [3:0] C_PLAY  = 4'b0010;
    localparam logic [3:0] C_REC   = 4'b0100;
    localparam logic [3:0] C_STOP  = 4'b1000;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ARM    = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] RECORD = 3'd3;
    localparam logic [2:0] PLAY   = 3'd4;
    localparam logic [2:0] PAUSED = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        rec_cmd, play_cmd, pause_cmd, stop_cmd;
    logic [3:0]  song_sel;
    logic        ready, song_done;
    logic        start_song, pause_song, record_mode, mem_we;
    logic        done_pulse, bad_cmd;
    logic [3:0]  song_choice;
    logic [15:0] recorded;
    logic [2:0]  state_out;

    song_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .rec_cmd_i     (rec_cmd),
        .play_cmd_i    (play_cmd),
        .pause_cmd_i   (pause_cmd),
        .stop_cmd_i    (stop_cmd),
        .song_sel_i    (song_sel),
        .ready_i       (ready),
        .song_done_i   (song_done),
        .start_song_o  (start_song),
        .pause_song_o  (pause_song),
        .record_mode_o (record_mode),
        .song_choice_o (song_choice),
        .mem_we_o      (mem_we),
        .done_pulse_o  (done_pulse),
        .bad_cmd_o     (bad_cmd),
        .recorded_o    (recorded),
        .state_out_o   (state_out)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           vec_cnt = 0;
    int           err_cnt = 0;

    // Take-level expectations maintained by the test sequence.
    logic [3:0]  exp_choice;
    logic        exp_rmode;
    logic [15:0] exp_rec;

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (state got %0d exp %0d)",
                     tag, got, exp, got[W-1 -: 3], exp[W-1 -: 3]);
        end
    endtask

    function automatic logic [W-1:0] expect_word(input logic [2:0] es,
                                                 input logic eb,
                                                 input logic rdy,
                                                 input logic sd);
        logic st, ps, dn, we;
        st = (es == ARM);
        ps = (es == IDLE) || (es == PAUSED) || (es == DONE);
        dn = (es == DONE);
        we = (es == RECORD) && rdy && !sd;
        return {es, st, ps, exp_rmode, exp_choice, dn, eb, we, exp_rec};
    endfunction

    task automatic monitor(input string tag);
        if (exp_q.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL %s: scoreboard empty, got %h expected entry",
                     tag, {state_out, start_song, pause_song, record_mode,
                           song_choice, done_pulse, bad_cmd, mem_we, recorded});
        end else begin
            check(tag, {state_out, start_song, pause_song, record_mode,
                        song_choice, done_pulse, bad_cmd, mem_we, recorded},
                  exp_q.pop_front());
        end
    endtask

    // ---------------- driver ----------------
    task automatic apply(input logic [3:0] cmd, input logic [3:0] sel,
                         input logic rdy, input logic sd,
                         input logic [2:0] es, input logic eb,
                         input string tag);
        {stop_cmd, rec_cmd, play_cmd, pause_cmd} = cmd;
        song_sel  = sel;
        ready     = rdy;
        song_done = sd;
        exp_q.push_back(expect_word(es, eb, rdy, sd));
        @(posedge clk);
        #1;
        {stop_cmd, rec_cmd, play_cmd, pause_cmd} = C_NONE;
        monitor(tag);
    endtask

    // ---------------- sequence ----------------
    initial begin
        reset = 1'b1;
        {stop_cmd, rec_cmd, play_cmd, pause_cmd} = C_NONE;
        song_sel = 4'd0; ready = 1'b0; song_done = 1'b0;
        exp_choice = 4'd0; exp_rmode = 1'b0; exp_rec = 16'd0;

        apply(C_NONE, 4'd5, 1'b1, 1'b0, IDLE, 1'b0, "reset_a");
        apply(C_REC,  4'd2, 1'b1, 1'b0, IDLE, 1'b0, "reset_b");
        reset = 1'b0;
        apply(C_NONE, 4'd2, 1'b1, 1'b0, IDLE, 1'b0, "post_reset");

        // Record slot 2 with ready high.
        exp_choice = 4'd2; exp_rmode = 1'b1;
        apply(C_REC,  4'd2, 1'b1, 1'b0, ARM,    1'b0, "rec2_arm");
        apply(C_NONE, 4'd2, 1'b1, 1'b0, SETTLE, 1'b0, "rec2_settle");
        exp_rec[2] = 1'b1;
        apply(C_NONE, 4'd2, 1'b1, 1'b0, RECORD, 1'b0, "rec2_record");
        apply(C_NONE, 4'd6, 1'b1, 1'b0, RECORD, 1'b0, "rec2_we_sel_ignored");
        apply(C_REC,  4'd2, 1'b1, 1'b0, RECORD, 1'b1, "rec_in_record_bad");
        apply(C_PLAY, 4'd2, 1'b0, 1'b0, RECORD, 1'b1, "play_in_record_bad");
        apply(C_NONE, 4'd2, 1'b1, 1'b0, RECORD, 1'b0, "rec2_we_again");
        apply(C_NONE, 4'd2, 1'b1, 1'b1, DONE,   1'b0, "rec2_done");
        apply(C_NONE, 4'd2, 1'b1, 1'b0, IDLE,   1'b0, "rec2_idle");

        // Rejected commands in IDLE.
        apply(C_REC,  4'd7,  1'b0, 1'b0, IDLE, 1'b1, "rec_invalid7");
        apply(C_NONE, 4'd7,  1'b0, 1'b0, IDLE, 1'b0, "bad_one_cycle");
        apply(C_PLAY, 4'd9,  1'b0, 1'b0, IDLE, 1'b1, "play_unrecorded9");
        apply(C_REC,  4'd14, 1'b0, 1'b0, IDLE, 1'b1, "rec_invalid14");
        apply(C_PAUSE, 4'd2, 1'b0, 1'b0, IDLE, 1'b0, "pause_in_idle");
        apply(C_STOP, 4'd2,  1'b0, 1'b0, IDLE, 1'b0, "stop_in_idle");

        // Play slot 2, pause, resume with play while song_sel moved.
        exp_rmode = 1'b0;
        apply(C_PLAY, 4'd2, 1'b1, 1'b0, ARM,    1'b0, "play2_arm");
        apply(C_NONE, 4'd2, 1'b1, 1'b0, SETTLE, 1'b0, "play2_settle");
        apply(C_NONE, 4'd2, 1'b1, 1'b0, PLAY,   1'b0, "play2_play_no_we");
        apply(C_PAUSE, 4'd2, 1'b1, 1'b0, PAUSED, 1'b0, "play2_paused");
        apply(C_REC,  4'd4, 1'b1, 1'b0, PAUSED, 1'b1, "rec_in_paused_bad");
        apply(C_PLAY, 4'd4, 1'b1, 1'b0, PLAY,   1'b0, "resume_keeps_choice");
        apply(C_STOP | C_PAUSE | C_REC, 4'd4, 1'b1, 1'b0, IDLE, 1'b0,
              "stop_priority");

        // song_done held through SETTLE is ignored, then ends the take.
        apply(C_PLAY, 4'd2, 1'b0, 1'b1, ARM,    1'b0, "sd_arm");
        apply(C_NONE, 4'd2, 1'b0, 1'b1, SETTLE, 1'b0, "sd_settle");
        apply(C_NONE, 4'd2, 1'b0, 1'b1, PLAY,   1'b0, "sd_ignored_play");
        apply(C_NONE, 4'd2, 1'b0, 1'b1, DONE,   1'b0, "sd_done");
`ifdef LOOP_PLAYBACK_EN
        apply(C_NONE, 4'd2, 1'b0, 1'b0, ARM,    1'b0, "loop_rearm");
        apply(C_NONE, 4'd2, 1'b0, 1'b0, SETTLE, 1'b0, "loop_settle");
        apply(C_NONE, 4'd2, 1'b0, 1'b0, PLAY,   1'b0, "loop_play");
        apply(C_NONE, 4'd2, 1'b0, 1'b1, DONE,   1'b0, "loop_done");
        apply(C_STOP, 4'd2, 1'b0, 1'b0, IDLE,   1'b0, "loop_stop_in_done");
`else
        apply(C_NONE, 4'd2, 1'b0, 1'b0, IDLE,   1'b0, "done_to_idle");
`endif

        // rec and play together: rec wins; slot 9 legal for recording.
        exp_choice = 4'd9; exp_rmode = 1'b1;
        apply(C_REC | C_PLAY, 4'd9, 1'b1, 1'b0, ARM, 1'b0, "rec_beats_play");
        apply(C_NONE, 4'd9, 1'b1, 1'b0, SETTLE, 1'b0, "rec9_settle");
        exp_rec[9] = 1'b1;
        apply(C_NONE, 4'd9, 1'b1, 1'b0, RECORD, 1'b0, "rec9_record");
        apply(C_STOP, 4'd9, 1'b1, 1'b0, IDLE,   1'b0, "rec9_stop");

        // Boundary slot 13, then reset mid-take clears everything.
        exp_choice = 4'd13;
        apply(C_REC,  4'd13, 1'b1, 1'b0, ARM,    1'b0, "rec13_arm");
        apply(C_NONE, 4'd13, 1'b1, 1'b0, SETTLE, 1'b0, "rec13_settle");
        exp_rec[13] = 1'b1;
        apply(C_NONE, 4'd13, 1'b1, 1'b0, RECORD, 1'b0, "rec13_record");
        reset = 1'b1;
        exp_choice = 4'd0; exp_rmode = 1'b0; exp_rec = 16'd0;
        apply(C_NONE, 4'd13, 1'b1, 1'b0, IDLE, 1'b0, "midtake_reset");
        reset = 1'b0;
        apply(C_PLAY, 4'd2, 1'b1, 1'b0, IDLE, 1'b1, "play_after_reset_bad");

        // Random idle-time commands on invalid slots must all be rejected.
        for (int i = 0; i < 4; i++) begin
            logic [3:0] s;
            s = (($urandom_range(0, 1) == 0) ? 4'd6 : 4'd14) +
                4'($urandom_range(0, 1));
            apply(C_REC, s, 1'b0, 1'b0, IDLE, 1'b1, "rand_invalid_rec");
        end

        if (exp_q.size() != 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL leftover: %0d entries remain, expected 0",
                     exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
